// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage:
//               FSM state encoding, reset defaults and the PC step.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,    // request outstanding at pc
        ST_VALID = 2'd1,    // instruction presented to IF/ID
        ST_DROP  = 2'd2     // squashed request still in flight
    } if_state_t;

    localparam logic [31:0] c_reset_pc  = 32'h0000_0000;
    localparam logic [31:0] c_nop_instr = 32'h0000_0000;
    localparam logic [31:0] c_pc_inc    = 32'd4;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + c_pc_inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : if_wait_timer
// Description : Saturating count of ready-less memory request cycles with a
//               sticky timeout flag.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               cnt_en        - a request cycle went unanswered
//               clr           - response or redirect; restart the count
//               fetch_err     - sticky, set when the count reaches MAX_WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module if_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,
    input  logic clr,
    output logic fetch_err
);

    localparam int                 c_cnt_w = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_WAIT);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (clr) begin
            // Only the count restarts; the error flag stays sticky.
            r_cnt <= '0;
        end else if (cnt_en && (r_cnt != c_max)) begin
            r_cnt <= r_cnt + c_one;
            if (r_cnt == (c_max - c_one)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign fetch_err = r_err;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Owns the PC, requests instruction
//               memory and presents one instruction per fetch to IF/ID.
// Ports       : clk, rst                    - clock, sync active-high reset
//               stall                       - hold PC and presented instruction
//               branch_taken/branch_target  - redirect (highest priority)
//               jump/jump_target            - redirect
//               imem_req/imem_addr          - memory request, address
//               imem_ready/imem_rdata       - memory response
//               Write                       - IF/ID load strobe
//               instruction_out, PCNow_out, PCNext4_out - fetched instruction
//               fetch_err                   - sticky memory timeout
//               stall_cnt                   - only with IF_STALL_CNT_EN
// Options     : define IF_STALL_CNT_EN to add the stall_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_reset_pc,
    parameter logic [31:0] NOP_INSTR = c_nop_instr,
    parameter int          MAX_WAIT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        Write,
    output logic [31:0] instruction_out,
    output logic [31:0] PCNow_out,
    output logic [31:0] PCNext4_out,
`ifdef IF_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        fetch_err
);

    if_state_t   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;   // address of the squashed request in DROP
    logic [31:0] r_instr;
    logic [31:0] r_pc_now;
    logic [31:0] r_pc_next4;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_in_req;
    logic        w_wait;

    // Branch belongs to the older instruction, so it beats a jump.
    assign w_redirect = branch_taken | jump;
    assign w_target   = branch_taken ? branch_target : jump_target;
    assign w_in_req   = (r_state == ST_FETCH) || (r_state == ST_DROP);
    assign w_wait     = w_in_req && !imem_ready;

    assign imem_req  = w_in_req && !rst;
    // DROP keeps the squashed address on the bus until memory answers it.
    assign imem_addr = (r_state == ST_DROP) ? r_drop_addr : r_pc;
    assign Write     = (r_state == ST_VALID) && !stall && !w_redirect && !rst;

    assign instruction_out = r_instr;
    assign PCNow_out       = r_pc_now;
    assign PCNext4_out     = r_pc_next4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_PC;
            r_drop_addr <= RESET_PC;
            r_instr     <= NOP_INSTR;
            r_pc_now    <= RESET_PC;
            r_pc_next4  <= pc_inc(RESET_PC);
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_redirect) begin
                        // Any data arriving now belongs to the old path.
                        r_pc <= w_target;
                        if (!imem_ready) begin
                            r_drop_addr <= r_pc;
                            r_state     <= ST_DROP;
                        end
                    end else if (imem_ready) begin
                        r_instr    <= imem_rdata;
                        r_pc_now   <= r_pc;
                        r_pc_next4 <= pc_inc(r_pc);
                        r_state    <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= ST_FETCH;
                    end else if (!stall) begin
                        r_pc    <= pc_inc(r_pc);
                        r_state <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end else if (imem_ready) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    if_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .cnt_en    (w_wait),
        .clr       ((w_in_req && imem_ready) || w_redirect),
        .fetch_err (fetch_err)
    );

`ifdef IF_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall_evt;

    assign w_stall_evt = w_wait || ((r_state == ST_VALID) && stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Stall counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage. A memory model with
//               variable latency answers requests; a scoreboard queue holds
//               the PC of the next instruction expected in program order and
//               a monitor checks every Write against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam int          c_max_wait = 255;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        Write;
    logic [31:0] instruction_out;
    logic [31:0] PCNow_out;
    logic [31:0] PCNext4_out;
    logic        fetch_err;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .Write           (Write),
        .instruction_out (instruction_out),
        .PCNow_out       (PCNow_out),
        .PCNext4_out     (PCNext4_out),
`ifdef IF_STALL_CNT_EN
        .stall_cnt       (stall_cnt),
`endif
        .fetch_err       (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk    = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    logic [31:0] q[$];          // PC of the next instruction in program order
    int          fixed_lat = 0; // -1 selects random latency 0..3
    logic        mem_hold  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Drive redirect inputs for one cycle and retarget the expected stream.
    task automatic drive(input logic b, input logic [31:0] bt, input logic j, input logic [31:0] jt);
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        if (b) begin
            q.delete();
            q.push_back(bt);
        end else if (j) begin
            q.delete();
            q.push_back(jt);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        q.delete();
        q.push_back(c_reset_pc);
        repeat (n) cyc();
    endtask

    task automatic wait_write(input string nm, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            smp();
            if (Write) begin
                found = 1'b1;
                break;
            end
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    // Memory model: one outstanding request, latency fixed or random.
    logic        m_busy = 1'b0;
    logic [31:0] m_addr = 32'h0;
    int          m_lat  = 0;
    initial begin
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                m_busy     = 1'b0;
                imem_ready = 1'b0;
            end else if (imem_req) begin
                if (!m_busy) begin
                    m_busy = 1'b1;
                    m_addr = imem_addr;
                    m_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end else begin
                    chk("addr_stable", imem_addr, m_addr);
                end
                if (!mem_hold && m_lat == 0) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_word(m_addr);
                    m_busy     = 1'b0;
                end else begin
                    imem_ready = 1'b0;
                    imem_rdata = $urandom;
                    if (m_lat > 0) m_lat--;
                end
            end else begin
                imem_ready = 1'b0;
                m_busy     = 1'b0;
            end
        end
    end

    // Monitor: every Write must deliver the next instruction in program order.
    logic        mon_prev_w = 1'b0;
    logic [31:0] mon_exp;
    initial begin
        forever begin
            smp();
            if (rst) begin
                mon_prev_w = 1'b0;
            end else begin
                if (Write) begin
                    n_writes++;
                    if (q.size() == 0) begin
                        chk("sb_empty", 32'(q.size()), 32'd1);
                    end else begin
                        mon_exp = q.pop_front();
                        chk("sb_pcnow", PCNow_out, mon_exp);
                        chk("sb_instr", instruction_out, mem_word(mon_exp));
                        chk("sb_pcnext4", PCNext4_out, mon_exp + 32'd4);
                        q.push_back(mon_exp + 32'd4);
                    end
                    chk("sb_write_gap", 32'(mon_prev_w), 32'd0);
                    chk("sb_write_stall", 32'(stall), 32'd0);
                    chk("sb_write_req", 32'(imem_req), 32'd0);
                end
                mon_prev_w = Write;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic        found;
    int          wrote;
    logic [31:0] rt;

    initial begin
        rst = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;

        // Reset values and zero-wait fetch timing.
        do_reset(3);
        smp();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_write", 32'(Write), 32'd0);
        chk("rst_instr", instruction_out, 32'h0);
        chk("rst_pcnow", PCNow_out, c_reset_pc);
        chk("rst_pcnext4", PCNext4_out, c_reset_pc + 32'd4);
        chk("rst_err", 32'(fetch_err), 32'd0);
        cyc(); rst = 1'b0;
        smp();
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        cyc(); smp();
        chk("c1_write", 32'(Write), 32'd1);
        chk("c1_instr", instruction_out, 32'h2008_0005);
        chk("c1_pcnow", PCNow_out, 32'h0);
        chk("c1_pcnext4", PCNext4_out, 32'h4);
        cyc(); smp();
        chk("c2_req", 32'(imem_req), 32'd1);
        chk("c2_addr", imem_addr, 32'h4);

        // Three stall cycles in VALID.
        cyc(); stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("stall_write", 32'(Write), 32'd0);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_instr", instruction_out, mem_word(32'h4));
            chk("stall_pcnow", PCNow_out, 32'h4);
            if (k < 2) cyc();
        end
        cyc(); stall = 1'b0; fixed_lat = 3;
        smp();
        chk("unstall_write", 32'(Write), 32'd1);
        chk("unstall_pcnow", PCNow_out, 32'h4);

        // Branch on the first wait cycle of a 3-cycle-latency fetch.
        cyc(); drive(1'b1, 32'h40, 1'b0, 32'h0);
        smp();
        chk("br_addr0", imem_addr, 32'h8);
        cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0);
        smp();
        chk("br_drop_req", 32'(imem_req), 32'd1);
        chk("br_drop_addr", imem_addr, 32'h8);
        wrote = 0; found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(); smp();
            if (Write) wrote++;
            if (imem_req && imem_addr == 32'h40) begin
                found = 1'b1;
                break;
            end
        end
        chk("br_found_target", 32'(found), 32'd1);
        chk("br_no_write", 32'(wrote), 32'd0);
        fixed_lat = 0;
        wait_write("br_write_timeout", 20);
        chk("br_pcnow", PCNow_out, 32'h40);

        // Branch and jump together while stalled in VALID.
        cyc(); stall = 1'b1;
        smp();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!imem_req) begin
                found = 1'b1;
                break;
            end
            cyc(); smp();
        end
        chk("bj_reach_valid", 32'(found), 32'd1);
        cyc(); drive(1'b1, 32'h100, 1'b1, 32'h200);
        smp();
        chk("bj_write", 32'(Write), 32'd0);
        cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0); stall = 1'b0; mem_hold = 1'b1;
        smp();
        chk("bj_req", 32'(imem_req), 32'd1);
        chk("bj_addr", imem_addr, 32'h100);

        // Memory timeout: cycle 1 of the wait was the one just sampled.
        repeat (c_max_wait - 1) cyc();
        smp();
        chk("to_err_before", 32'(fetch_err), 32'd0);
        cyc(); smp();
        chk("to_err_set", 32'(fetch_err), 32'd1);
        cyc(); mem_hold = 1'b0;
        wait_write("to_write_timeout", 20);
        chk("to_pcnow", PCNow_out, 32'h100);
        chk("to_err_sticky", 32'(fetch_err), 32'd1);
        cyc(); do_reset(1);
        smp();
        chk("to_err_clr", 32'(fetch_err), 32'd0);
        cyc(); rst = 1'b0;
        smp();
        chk("to_req", 32'(imem_req), 32'd1);
        chk("to_addr", imem_addr, c_reset_pc);

        // PC wrap at the top of the address space.
        cyc(); drive(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        smp();
        cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0);
        smp();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_write("wrap_write_timeout", 20);
        chk("wrap_pcnow", PCNow_out, 32'hFFFF_FFFC);
        chk("wrap_pcnext4", PCNext4_out, 32'h0);
        cyc(); smp();
        chk("wrap_next_req", 32'(imem_req), 32'd1);
        chk("wrap_next_addr", imem_addr, 32'h0);

`ifdef IF_STALL_CNT_EN
        // Two wait cycles plus two stall cycles.
        cyc(); do_reset(2);
        smp();
        chk("sc_rst", stall_cnt, 32'd0);
        fixed_lat = 2;
        cyc(); rst = 1'b0; stall = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        cyc(); stall = 1'b0;
        smp();
        chk("sc_write", 32'(Write), 32'd1);
        chk("sc_value", stall_cnt, 32'd4);
`endif

        // Randomized traffic: latency, stalls and redirects.
        fixed_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            stall = ($urandom_range(0, 9) < 3);
            rt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                             : ($urandom & 32'h0000_FFFC);
            case ($urandom_range(0, 19))
                0:       drive(1'b1, rt, 1'b0, $urandom);
                1:       drive(1'b1, rt, 1'b1, $urandom & 32'hFFFF_FFFC);
                2:       drive(1'b0, $urandom, 1'b1, rt);
                default: drive(1'b0, $urandom, 1'b0, $urandom);
            endcase
        end
        cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0); stall = 1'b0;
        repeat (10) cyc();
        smp();
        chk("rnd_progress", 32'(n_writes > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, issues requests to instruction memory, and delivers one instruction per fetch to the IF/ID pipeline register.
- Drives that register's Write strobe together with instruction_out, PCNow_out and PCNext4_out.
- Accepts stall from the hazard unit and branch/jump redirects from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction value presented on reset.
- MAX_WAIT, 255, number of consecutive ready-less request cycles before fetch_err sets.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous to clk, active-high.
- stall  in  1  hazard hold: hold the PC and the presented instruction.
- branch_taken  in  1  branch redirect.
- branch_target  in  32  redirect PC for branch_taken.
- jump  in  1  jump redirect.
- jump_target  in  32  redirect PC for jump.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ready  in  1  memory response valid this cycle.
- imem_rdata  in  32  instruction word, sampled when imem_req&imem_ready.
- Write  out  1  load strobe to the IF/ID register.
- instruction_out  out  32  fetched instruction.
- PCNow_out  out  32  PC of the fetched instruction.
- PCNext4_out  out  32  PCNow_out+4, modulo 2^32.
- fetch_err  out  1  sticky memory-timeout flag.

Behaviour:
- Single clock clk. rst is synchronous and active-high; it is sampled only on posedge clk.
- Reset values:
  - state=FETCH, pc=RESET_PC.
  - instruction_out=NOP_INSTR, PCNow_out=RESET_PC, PCNext4_out=RESET_PC+4.
  - Write=0, fetch_err=0, wait counter=0.
  - imem_req is forced 0 while rst=1.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: register imem_rdata into instruction_out, pc into PCNow_out, pc+4 into PCNext4_out; go to VALID.
- State VALID:
  - imem_req=0. Write=!stall (combinational).
  - Write=1: pc<=pc+4, go to FETCH.
  - stall=1: remain in VALID; outputs and pc hold.
- State DROP:
  - imem_req=1, imem_addr holds the old address.
  - On imem_ready: discard the data; go to FETCH at the already-updated pc.
- Redirect:
  - Redirect is branch_taken|jump. branch_taken has priority over jump (the older instruction wins). Redirect overrides stall.
  - In FETCH without imem_ready: pc<=target, go to DROP.
  - In FETCH with imem_ready: discard the data, pc<=target, go to FETCH.
  - In VALID: Write is forced 0 that cycle, pc<=target, go to FETCH.
  - In DROP: pc<=target, stay in DROP.
- Write asserts at most once per instruction and never in two consecutive cycles.
- Zero-wait memory gives 2 cycles per instruction: FETCH, then VALID.
- Wait counter:
  - Increments each FETCH/DROP cycle without imem_ready; clears on imem_ready or redirect.
  - Saturates at MAX_WAIT; reaching MAX_WAIT sets fetch_err.
  - fetch_err clears only on rst. The fetch keeps waiting after fetch_err sets.
- PC arithmetic: unsigned 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000. Targets are used as given; there is no alignment check.
- Reset mid-operation: an outstanding request is abandoned. The next cycle after rst deasserts is FETCH at RESET_PC, and any late imem_ready is ignored.

Optional Feature:
- Macro IF_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0].
  - Increments every cycle in which the state is FETCH or DROP without imem_ready, or VALID with stall=1.
  - Saturates at 0xFFFF_FFFF; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package if_pkg holds the state encoding (FETCH, VALID, DROP), the NOP_INSTR and RESET_PC defaults, and the PC increment constant 4.
- One sub-module, if_wait_timer: saturating wait counter plus sticky fetch_err. Inputs: clk, rst, count enable, clear. MAX_WAIT is its parameter.

Test Plan:
- Zero-wait memory, word at addr 0 = 0x20080005, rst held then released -> cycle 0 imem_req=1 addr 0x0; cycle 1 Write=1, instruction_out=0x20080005, PCNow_out=0x0, PCNext4_out=0x4; cycle 2 addr 0x4.
- stall=1 for 3 cycles while in VALID -> Write=0 for 3 cycles, outputs stable, imem_req=0; Write=1 on the first cycle with stall=0.
- Memory latency 3; branch_taken=1 with target 0x40 on the first wait cycle -> old response discarded, no Write; next request addr 0x40; Write with PCNow_out=0x40.
- branch_taken=1 (target 0x100) and jump=1 (target 0x200) in VALID with stall=1 -> Write=0; next fetch addr 0x100.
- imem_ready held 0 for MAX_WAIT cycles -> fetch_err=1 and stays 1 after ready returns; rst clears it; the next fetch is at RESET_PC.
- pc=0xFFFF_FFFC delivered -> PCNext4_out=0x0, next fetch addr 0x0. With IF_STALL_CNT_EN, 2 wait + 2 stall cycles -> stall_cnt=4.
